// File: rtl/my_adc_packer_pkg.sv
// Shared types and helpers for my_adc_packer: FSM states, word/lane widths, FIFO entry layout.
package my_adc_pkg;

   localparam int LANE_W = 16;
   localparam int OUT_W  = 32;
   localparam int ENT_W  = OUT_W + 2;

   typedef enum logic [1:0] {
      IDLE,
      EVEN,
      ODD,
      DISCARD
   } state_e;

   typedef struct packed {
      logic             sop;
      logic             eop;
      logic [OUT_W-1:0] data;
   } fifo_ent_t;

   // Sample arrives already zero-extended; the tag fills the top nibble (zero when tagging is off).
   function automatic logic [LANE_W-1:0] pack_lane(input logic [LANE_W-1:0] sample,
                                                   input logic [3:0]        tag);
      return sample | {tag, {(LANE_W-4){1'b0}}};
   endfunction

endpackage

// File: rtl/my_adc_packer_fifo.sv
// Show-ahead FIFO for packed words. Two ordered write ports so a stale-packet closer and the
// new packet's first word can both land in the same cycle.
module my_adc_packer_fifo
   import my_adc_pkg::*;
#(
   parameter int WIDTH = ENT_W,
   parameter int DEPTH = 16
) (
   input  logic                          csi_clk,
   input  logic                          rsi_reset_n,
   input  logic [1:0]                    wr_en,
   input  logic [1:0][WIDTH-1:0]         wr_data,
   input  logic                          rd_en,
   output logic [WIDTH-1:0]              rd_data,
   output logic                          empty,
   output logic [$clog2(DEPTH):0]        used
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, wr_ptr1;

   assign wr_ptr1 = wr_ptr + 1'b1;

   // Port 1 is only ever used together with port 0 and lands right behind it.
   always_ff @(posedge csi_clk) begin
      if (wr_en[0]) mem[wr_ptr[AW-1:0]]  <= wr_data[0];
      if (wr_en[1]) mem[wr_ptr1[AW-1:0]] <= wr_data[1];
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + (AW+1)'(wr_en[0]) + (AW+1)'(wr_en[1]);
         rd_ptr <= rd_ptr + (AW+1)'(rd_en);
      end
   end

   assign used    = wr_ptr - rd_ptr;
   assign empty   = (used == '0);
   assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/my_adc_packer.sv
// Packs 12-bit ADC sequencer samples two per 32-bit word into a framed, backpressured stream.
// Define MY_ADC_PACKER_CHTAG_EN to place channel[3:0] in each lane's top nibble.
module my_adc_packer
   import my_adc_pkg::*;
#(
   parameter int DATA_W      = 12,
   parameter int CH_W        = 5,
   parameter int MAX_SAMPLES = 32,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic              csi_clk,
   input  logic              rsi_reset_n,
   input  logic [DATA_W-1:0] asi_in0_data,
   input  logic              asi_in0_valid,
   input  logic [CH_W-1:0]   asi_in0_channel,
   input  logic              asi_in0_startofpacket,
   input  logic              asi_in0_endofpacket,
   output logic [31:0]       aso_out0_data,
   output logic              aso_out0_valid,
   input  logic              aso_out0_ready,
   output logic              aso_out0_startofpacket,
   output logic              aso_out0_endofpacket,
   output logic [15:0]       coe_drop_count
);

   localparam int MAX_WORDS = (MAX_SAMPLES + 1) / 2;
   localparam int IDX_W     = $clog2(MAX_SAMPLES + 1);
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

   state_e              state_q, state_d;
   logic [LANE_W-1:0]   lane_lo_q, lane_lo_d;
   logic                first_q, first_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [15:0]         drop_q;
   logic                drop_inc;

   logic                sop, eop, need_close, fits;
   logic [3:0]          tag;
   logic [LANE_W-1:0]   cur_lane;
   logic                take, to_hi, is_first, last;
   logic [IDX_W-1:0]    cur_idx;
   logic                close_w, word_w;
   fifo_ent_t           close_ent, word_ent, rd_ent;
   logic [1:0]          wr_en;
   fifo_ent_t [1:0]     wr_ent;
   logic                rd_en, fifo_empty;
   logic [CNT_W-1:0]    used;
   logic                unused_ch;

   assign sop = asi_in0_startofpacket;
   assign eop = asi_in0_endofpacket;

`ifdef MY_ADC_PACKER_CHTAG_EN
   assign tag = 4'(asi_in0_channel);
`else
   assign tag = 4'h0;
`endif
   assign unused_ch = ^asi_in0_channel;

   assign cur_lane = pack_lane(LANE_W'(asi_in0_data), tag);

   // A stale packet is closed in the same cycle as the new sop, so its word counts against free space.
   assign need_close = asi_in0_valid & sop & ((state_q == ODD) | (state_q == EVEN));
   assign fits = (32'(used) + 32'(need_close) + MAX_WORDS) <= FIFO_DEPTH;

   always_comb begin
      state_d   = state_q;
      lane_lo_d = lane_lo_q;
      first_d   = first_q;
      idx_d     = idx_q;
      drop_inc  = 1'b0;
      close_w   = need_close;
      close_ent = '0;
      word_w    = 1'b0;
      word_ent  = '0;
      take      = 1'b0;
      to_hi     = 1'b0;
      is_first  = 1'b0;
      cur_idx   = '0;
      last      = 1'b0;

      if (asi_in0_valid) begin
         if (sop) begin
            // ODD holds a half word to flush; EVEN can only be closed with an empty eop word.
            close_ent.eop = 1'b1;
            if (state_q == ODD) begin
               close_ent.sop  = first_q;
               close_ent.data = {{LANE_W{1'b0}}, lane_lo_q};
            end
            if (fits) begin
               take     = 1'b1;
               is_first = 1'b1;
            end else begin
               drop_inc = 1'b1;
               state_d  = eop ? IDLE : DISCARD;
            end
         end else begin
            unique case (state_q)
               EVEN: begin
                  take    = 1'b1;
                  cur_idx = idx_q;
               end
               ODD: begin
                  take    = 1'b1;
                  to_hi   = 1'b1;
                  cur_idx = idx_q;
               end
               DISCARD: if (eop) state_d = IDLE;
               default: ;
            endcase
         end
      end

      if (take) begin
         last  = (cur_idx == IDX_W'(MAX_SAMPLES - 1));
         idx_d = cur_idx + 1'b1;
         if (to_hi) begin
            word_w        = 1'b1;
            word_ent.sop  = first_q;
            word_ent.eop  = eop | last;
            word_ent.data = {cur_lane, lane_lo_q};
            state_d       = EVEN;
         end else if (eop | last) begin
            word_w        = 1'b1;
            word_ent.sop  = is_first;
            word_ent.eop  = 1'b1;
            word_ent.data = {{LANE_W{1'b0}}, cur_lane};
         end else begin
            lane_lo_d = cur_lane;
            first_d   = is_first;
            state_d   = ODD;
         end
         if (eop)       state_d = IDLE;
         else if (last) state_d = DISCARD;
      end
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         state_q   <= IDLE;
         lane_lo_q <= '0;
         first_q   <= 1'b0;
         idx_q     <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         lane_lo_q <= lane_lo_d;
         first_q   <= first_d;
         idx_q     <= idx_d;
         if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      end
   end

   // Closer always goes first so packet order is preserved.
   assign wr_en[0]  = close_w | word_w;
   assign wr_en[1]  = close_w & word_w;
   assign wr_ent[0] = close_w ? close_ent : word_ent;
   assign wr_ent[1] = word_ent;

   my_adc_packer_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .csi_clk     (csi_clk),
      .rsi_reset_n (rsi_reset_n),
      .wr_en       (wr_en),
      .wr_data     (wr_ent),
      .rd_en       (rd_en),
      .rd_data     (rd_ent),
      .empty       (fifo_empty),
      .used        (used)
   );

   assign aso_out0_valid         = ~fifo_empty;
   assign rd_en                  = aso_out0_valid & aso_out0_ready;
   assign aso_out0_data          = aso_out0_valid ? rd_ent.data : '0;
   assign aso_out0_startofpacket = aso_out0_valid & rd_ent.sop;
   assign aso_out0_endofpacket   = aso_out0_valid & rd_ent.eop;
   assign coe_drop_count         = drop_q;

endmodule

// File: tb/tb_my_adc_packer.sv
// Directed bench for my_adc_packer: a default instance (drop/reset) and a MAX_SAMPLES=4 instance
// (packing table, truncation).
module tb_my_adc_packer;

   logic        csi_clk = 1'b0;
   logic        rsi_reset_n;
   logic [11:0] asi_in0_data;
   logic        asi_in0_valid;
   logic [4:0]  asi_in0_channel;
   logic        asi_in0_startofpacket;
   logic        asi_in0_endofpacket;
   logic        aso_out0_ready;

   logic [31:0] aso_out0_data, s_data;
   logic        aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket;
   logic        s_valid, s_sop, s_eop;
   logic [15:0] coe_drop_count, s_drop;
   logic [34:0] ob, s_ob;

   int checks = 0;
   int errors = 0;

   always #5 csi_clk = ~csi_clk;

   my_adc_packer dut (
      .csi_clk                (csi_clk),
      .rsi_reset_n            (rsi_reset_n),
      .asi_in0_data           (asi_in0_data),
      .asi_in0_valid          (asi_in0_valid),
      .asi_in0_channel        (asi_in0_channel),
      .asi_in0_startofpacket  (asi_in0_startofpacket),
      .asi_in0_endofpacket    (asi_in0_endofpacket),
      .aso_out0_data          (aso_out0_data),
      .aso_out0_valid         (aso_out0_valid),
      .aso_out0_ready         (aso_out0_ready),
      .aso_out0_startofpacket (aso_out0_startofpacket),
      .aso_out0_endofpacket   (aso_out0_endofpacket),
      .coe_drop_count         (coe_drop_count)
   );

   my_adc_packer #(.MAX_SAMPLES(4), .FIFO_DEPTH(16)) dut_s (
      .csi_clk                (csi_clk),
      .rsi_reset_n            (rsi_reset_n),
      .asi_in0_data           (asi_in0_data),
      .asi_in0_valid          (asi_in0_valid),
      .asi_in0_channel        (asi_in0_channel),
      .asi_in0_startofpacket  (asi_in0_startofpacket),
      .asi_in0_endofpacket    (asi_in0_endofpacket),
      .aso_out0_data          (s_data),
      .aso_out0_valid         (s_valid),
      .aso_out0_ready         (aso_out0_ready),
      .aso_out0_startofpacket (s_sop),
      .aso_out0_endofpacket   (s_eop),
      .coe_drop_count         (s_drop)
   );

   assign ob   = {aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data};
   assign s_ob = {s_valid, s_sop, s_eop, s_data};

   typedef struct {
      logic        v, s, e, r;
      logic [11:0] d;
      logic [3:0]  c;
      logic [34:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [15:0] ln(input logic [3:0] c, input logic [11:0] x);
`ifdef MY_ADC_PACKER_CHTAG_EN
      return {c, x};
`else
      return {4'h0, x};
`endif
   endfunction

   function automatic logic [34:0] o(input logic vld, sp, ep, input logic [15:0] hi, lo);
      return {vld, sp, ep, hi, lo};
   endfunction

   function automatic vec_t mk(input logic v, s, e, input logic [11:0] d, input logic [3:0] c,
                               input logic r, input logic [34:0] x);
      vec_t t;
      t.v = v; t.s = s; t.e = e; t.d = d; t.c = c; t.r = r; t.exp = x;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step(input logic v, s, e, input logic [11:0] d, input logic [3:0] c, input logic r);
      asi_in0_valid         = v;
      asi_in0_startofpacket = s;
      asi_in0_endofpacket   = e;
      asi_in0_data          = d;
      asi_in0_channel       = 5'(c);
      aso_out0_ready        = r;
      @(posedge csi_clk);
      #1;
   endtask

   task automatic do_reset();
      asi_in0_valid = 1'b0; asi_in0_startofpacket = 1'b0; asi_in0_endofpacket = 1'b0;
      rsi_reset_n = 1'b0;
      #2;
      rsi_reset_n = 1'b1;
   endtask

   initial begin
      asi_in0_valid = 1'b0; asi_in0_startofpacket = 1'b0; asi_in0_endofpacket = 1'b0;
      asi_in0_data = '0; asi_in0_channel = '0; aso_out0_ready = 1'b1;
      rsi_reset_n = 1'b0;
      #1;
      chk("rst_out", 64'(ob), 64'h0);
      chk("rst_drop", 64'(coe_drop_count), 64'h0);
      chk("rst_out_s", 64'(s_ob), 64'h0);
      chk("rst_drop_s", 64'(s_drop), 64'h0);
      @(posedge csi_clk); #1;
      rsi_reset_n = 1'b1;

      // Packing table on dut_s; expected output is the head word after each beat's edge.
      vecs.push_back(mk(1,1,0,12'h101,0,1, 35'h0));
      vecs.push_back(mk(1,0,0,12'h202,1,1, o(1,1,0,ln(1,12'h202),ln(0,12'h101))));
      vecs.push_back(mk(1,0,0,12'h303,2,1, 35'h0));
      vecs.push_back(mk(1,0,1,12'h404,3,1, o(1,0,1,ln(3,12'h404),ln(2,12'h303))));
      vecs.push_back(mk(1,1,0,12'hAAA,4,1, 35'h0));
      vecs.push_back(mk(1,0,0,12'hBBB,5,1, o(1,1,0,ln(5,12'hBBB),ln(4,12'hAAA))));
      vecs.push_back(mk(1,0,1,12'hCCC,6,1, o(1,0,1,16'h0,ln(6,12'hCCC))));
      vecs.push_back(mk(1,1,1,12'h7FF,7,1, o(1,1,1,16'h0,ln(7,12'h7FF))));
      vecs.push_back(mk(0,0,0,12'h000,0,1, 35'h0));
      vecs.push_back(mk(1,1,0,12'h111,0,1, 35'h0));
      vecs.push_back(mk(1,1,0,12'h222,1,1, o(1,1,1,16'h0,ln(0,12'h111))));
      vecs.push_back(mk(1,0,1,12'h333,2,1, o(1,1,1,ln(2,12'h333),ln(1,12'h222))));
      vecs.push_back(mk(1,1,0,12'h444,0,1, 35'h0));
      vecs.push_back(mk(1,0,0,12'h555,1,1, o(1,1,0,ln(1,12'h555),ln(0,12'h444))));
      vecs.push_back(mk(1,1,1,12'h666,2,1, o(1,0,1,16'h0,16'h0)));
      vecs.push_back(mk(0,0,0,12'h000,0,1, o(1,1,1,16'h0,ln(2,12'h666))));
      vecs.push_back(mk(0,0,0,12'h000,0,1, 35'h0));
      vecs.push_back(mk(1,1,0,12'h010,3,0, 35'h0));
      vecs.push_back(mk(1,0,1,12'h020,4,0, o(1,1,1,ln(4,12'h020),ln(3,12'h010))));
      vecs.push_back(mk(0,0,0,12'h000,0,0, o(1,1,1,ln(4,12'h020),ln(3,12'h010))));
      vecs.push_back(mk(0,0,0,12'h000,0,1, 35'h0));
      vecs.push_back(mk(1,0,0,12'h999,5,1, 35'h0));
      vecs.push_back(mk(1,0,1,12'h888,6,1, 35'h0));

      foreach (vecs[i]) begin
         step(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d, vecs[i].c, vecs[i].r);
         chk($sformatf("vec%0d", i), 64'(s_ob), 64'(vecs[i].exp));
      end
      chk("vec_drop", 64'(s_drop), 64'h0);

      // Truncation at MAX_SAMPLES=4: samples 5-6 discarded, next packet normal.
      do_reset();
      step(1,1,0,12'h001,0,1); chk("tr_s0", 64'(s_ob), 64'h0);
      step(1,0,0,12'h002,1,1); chk("tr_w0", 64'(s_ob), 64'(o(1,1,0,ln(1,12'h002),ln(0,12'h001))));
      step(1,0,0,12'h003,2,1); chk("tr_s2", 64'(s_ob), 64'h0);
      step(1,0,0,12'h004,3,1); chk("tr_w1", 64'(s_ob), 64'(o(1,0,1,ln(3,12'h004),ln(2,12'h003))));
      step(1,0,0,12'h005,4,1); chk("tr_d5", 64'(s_ob), 64'h0);
      step(1,0,1,12'h006,5,1); chk("tr_d6", 64'(s_ob), 64'h0);
      step(1,1,0,12'h00A,6,1); chk("tr_n0", 64'(s_ob), 64'h0);
      step(1,0,1,12'h00B,7,1); chk("tr_n1", 64'(s_ob), 64'(o(1,1,1,ln(7,12'h00B),ln(6,12'h00A))));

      // Drop on the default instance: MAX_WORDS=16 equals depth, so any stored word blocks a sop.
      do_reset();
      step(1,1,0,12'h0A1,0,0);
      step(1,0,0,12'h0A2,0,0);
      step(1,0,1,12'h0A3,0,0);
      chk("dr_head", 64'(ob), 64'(o(1,1,0,ln(0,12'h0A2),ln(0,12'h0A1))));
      step(1,1,0,12'h0B1,0,0); chk("dr_cnt1", 64'(coe_drop_count), 64'd1);
      step(1,0,0,12'h0B2,0,0);
      step(1,0,1,12'h0B3,0,0);
      step(1,1,1,12'h0C1,0,0); chk("dr_cnt2", 64'(coe_drop_count), 64'd2);
      chk("dr_intact", 64'(ob), 64'(o(1,1,0,ln(0,12'h0A2),ln(0,12'h0A1))));
      step(0,0,0,12'h000,0,1); chk("dr_tail", 64'(ob), 64'(o(1,0,1,16'h0,ln(0,12'h0A3))));
      step(0,0,0,12'h000,0,1); chk("dr_empty", 64'(ob), 64'h0);
      step(1,1,1,12'h0D1,0,1); chk("dr_next", 64'(ob), 64'(o(1,1,1,16'h0,ln(0,12'h0D1))));
      step(0,0,0,12'h000,0,1);

      // Asynchronous reset mid-packet.
      step(1,1,0,12'h0E1,1,0);
      step(1,0,0,12'h0E2,2,0);
      chk("rs_pre", 64'(ob), 64'(o(1,1,0,ln(2,12'h0E2),ln(1,12'h0E1))));
      step(1,0,0,12'h0E3,3,0);
      #2 rsi_reset_n = 1'b0;
      #1;
      chk("rs_out", 64'(ob), 64'h0);
      chk("rs_drop", 64'(coe_drop_count), 64'h0);
      #1 rsi_reset_n = 1'b1;
      step(1,0,1,12'h0E4,4,1); chk("rs_ign", 64'(ob), 64'h0);
      step(1,1,1,12'h0F1,5,1); chk("rs_new", 64'(ob), 64'(o(1,1,1,16'h0,ln(5,12'h0F1))));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
